mole_spawner: RTL and testbench

Game sequencer that drives the load/loadval side of the board-state register. It emits pseudo-random mole patterns, one per round, from a 16-bit LFSR. It times each round and ends a round early when the board has been cleared. It shortens the round interval as the game progresses, counts missed moles, and clears the board at game end.

---
 rtl/mole_spawner_pkg.sv | 33 +++
 rtl/mole_spawner_lfsr16.sv | 38 +++
 rtl/mole_spawner.sv | 190 +++++++++++++++++++
 tb/tb_mole_spawner.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mole_spawner_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mole_spawner_pkg                                             |
// | Description : Shared definitions for the mole spawner. Holds the sequencer |
// |               state encoding, board geometry, the LFSR feedback mask and   |
// |               a popcount helper used for miss accounting.                  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
package mole_spawner_pkg;

  localparam int          NUM_HOLES = 5;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SPAWN = 3'd1,
    S_HOLD  = 3'd2,
    S_CLEAR = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  // Number of set bits in a board pattern (0..NUM_HOLES).
  function automatic logic [3:0] popcount(input logic [NUM_HOLES-1:0] v);
    logic [3:0] c;
    c = 4'd0;
    for (int i = 0; i < NUM_HOLES; i++) begin
      c = c + {3'b000, v[i]};
    end
    return c;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mole_spawner_lfsr16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : lfsr16                                                       |
// | Description : Free-running 16-bit Galois LFSR, right-shifting, feedback    |
// |               mask LFSR_MASK. Advances every clock outside reset.          |
// | Ports       : clk   - system clock                                         |
// |               rst_n - synchronous active-low reset (loads seed)            |
// |               seed  - reset value; an all-zero seed is replaced by 1       |
// |               q     - current LFSR state                                   |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module lfsr16
  import mole_spawner_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] seed,
  output logic [15:0] q
);

  logic [15:0] r_q;
  logic [15:0] w_seed;

  // An all-zero state would lock the LFSR up forever.
  assign w_seed = (seed == 16'h0000) ? 16'h0001 : seed;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_q <= w_seed;
    end else begin
      r_q <= {1'b0, r_q[15:1]} ^ (r_q[0] ? LFSR_MASK : 16'h0000);
    end
  end

  assign q = r_q;

endmodule
`default_nettype wire

// File: rtl/mole_spawner.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : mole_spawner                                                 |
// | Description : Whack-a-mole game sequencer. Drives the load/loadval side of |
// |               the board register with one pseudo-random pattern per round, |
// |               times each round (ending early when the board is cleared),   |
// |               shortens the round interval down to a floor, counts missed   |
// |               moles and clears the board at game end.                      |
// | Ports       : clk         - system clock                                   |
// |               rst_n       - synchronous active-low reset                   |
// |               start       - pulse; starts a game from IDLE or DONE         |
// |               board_state - live moles from the board register             |
// |               load        - one-cycle pulse to the board register          |
// |               loadval     - pattern to load, valid with load               |
// |               round       - current round index, 0-based                   |
// |               misses      - expired unhit moles, saturating at 255         |
// |               active      - high while spawning/holding                    |
// |               game_over   - high once the game has finished                |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module mole_spawner
  import mole_spawner_pkg::*;
#(
  parameter logic [31:0] TICKS_INIT = 32'd50_000_000,
  parameter logic [31:0] TICKS_STEP = 32'd2_000_000,
  parameter logic [31:0] TICKS_MIN  = 32'd10_000_000,
  parameter logic [7:0]  ROUNDS     = 8'd30,
  parameter logic [15:0] LFSR_SEED  = 16'hACE1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [4:0] board_state,
  output logic       load,
  output logic [4:0] loadval,
  output logic [7:0] round,
  output logic [7:0] misses,
  output logic       active,
  output logic       game_over
);

  // Widened so the underflow guard cannot itself overflow.
  localparam logic [32:0] c_step_plus_min = {1'b0, TICKS_STEP} + {1'b0, TICKS_MIN};

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_cnt;
  logic [31:0] w_cnt_nxt;
  logic [31:0] r_interval;
  logic [31:0] w_interval_nxt;
  logic [7:0]  r_round;
  logic [7:0]  w_round_nxt;
  logic [7:0]  r_misses;
  logic [7:0]  w_misses_nxt;
  logic        r_load;
  logic        w_load_nxt;
  logic [4:0]  r_loadval;
  logic [4:0]  w_loadval_nxt;
  logic        r_active;
  logic        w_active_nxt;
  logic        r_game_over;
  logic        w_game_over_nxt;

  logic [15:0] w_lfsr;
  logic        w_lfsr_unused;
  logic        w_all_hit;
  logic        w_cnt_zero;
  logic        w_round_end;
  logic        w_last_round;
  logic        w_start_game;
  logic [4:0]  w_pattern;
  logic [8:0]  w_miss_sum;
  logic [31:0] w_interval_dec;

  lfsr16 u_lfsr (
    .clk   (clk),
    .rst_n (rst_n),
    .seed  (LFSR_SEED),
    .q     (w_lfsr)
  );

  // Only the low bits pick the pattern; the rest just keep the sequence long.
  assign w_lfsr_unused  = ^w_lfsr[15:5];

  assign w_all_hit      = (board_state == 5'b00000);
  assign w_cnt_zero     = (r_cnt == 32'd0);
  assign w_round_end    = (r_state == S_HOLD) && (w_all_hit || w_cnt_zero);
  assign w_last_round   = (r_round == (ROUNDS - 8'd1));
  assign w_start_game   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Every round shows at least one mole.
  assign w_pattern      = (w_lfsr[4:0] == 5'b00000) ? 5'b00001 : w_lfsr[4:0];
  assign w_miss_sum     = {1'b0, r_misses} + {5'b00000, popcount(board_state)};
  assign w_interval_dec = ({1'b0, r_interval} < c_step_plus_min) ? TICKS_MIN
                                                                  : (r_interval - TICKS_STEP);

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE,
      S_DONE:  if (w_start_game) w_state_nxt = S_SPAWN;
      S_SPAWN: w_state_nxt = S_HOLD;
      S_HOLD:  if (w_round_end) w_state_nxt = w_last_round ? S_CLEAR : S_SPAWN;
      S_CLEAR: w_state_nxt = S_DONE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output / datapath next values. Outputs are registered, so they are
  // decoded from the state being entered rather than the current one.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_interval_nxt = r_interval;
    w_round_nxt    = r_round;
    w_misses_nxt   = r_misses;

    case (r_state)
      S_IDLE,
      S_DONE: begin
        if (w_start_game) begin
          w_round_nxt    = 8'd0;
          w_misses_nxt   = 8'd0;
          w_interval_nxt = TICKS_INIT;
        end
      end
      S_SPAWN: w_cnt_nxt = r_interval - 32'd1;
      S_HOLD: begin
        // A cleared board wins over a same-cycle timeout: no misses then.
        if (!w_all_hit) begin
          if (w_cnt_zero) begin
            w_misses_nxt = w_miss_sum[8] ? 8'hFF : w_miss_sum[7:0];
          end else begin
            w_cnt_nxt = r_cnt - 32'd1;
          end
        end
        if (w_round_end && !w_last_round) begin
          w_round_nxt    = r_round + 8'd1;
          w_interval_nxt = w_interval_dec;
        end
      end
      default: ;
    endcase

    w_load_nxt      = (w_state_nxt == S_SPAWN) || (w_state_nxt == S_CLEAR);
    w_loadval_nxt   = (w_state_nxt == S_SPAWN) ? w_pattern : 5'b00000;
    w_active_nxt    = (w_state_nxt == S_SPAWN) || (w_state_nxt == S_HOLD);
    w_game_over_nxt = (w_state_nxt == S_DONE);
  end

  // Output and datapath registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt       <= 32'd0;
      r_interval  <= TICKS_INIT;
      r_round     <= 8'd0;
      r_misses    <= 8'd0;
      r_load      <= 1'b0;
      r_loadval   <= 5'b00000;
      r_active    <= 1'b0;
      r_game_over <= 1'b0;
    end else begin
      r_cnt       <= w_cnt_nxt;
      r_interval  <= w_interval_nxt;
      r_round     <= w_round_nxt;
      r_misses    <= w_misses_nxt;
      r_load      <= w_load_nxt;
      r_loadval   <= w_loadval_nxt;
      r_active    <= w_active_nxt;
      r_game_over <= w_game_over_nxt;
    end
  end

  assign load      = r_load;
  assign loadval   = r_loadval;
  assign round     = r_round;
  assign misses    = r_misses;
  assign active    = r_active;
  assign game_over = r_game_over;

endmodule
`default_nettype wire

// File: tb/tb_mole_spawner.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_mole_spawner                                              |
// | Description : Self-checking bench for mole_spawner. Four instances with    |
// |               different parameter sets share one board-register model and  |
// |               one load monitor; the instance under test is picked by sel.  |
// | Revision    : 1.0 - initial release                                        |
// +----------------------------------------------------------------------------+
module tb_mole_spawner;

  localparam int N_DUT = 4;

  typedef struct {
    int gap;     // cycles since previous load (or since the start pulse)
    bit clear;   // this load is the end-of-game clear
    bit first;   // first load of a game
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       st   [N_DUT];
  logic [4:0] board_state = 5'b00000;
  logic       ld   [N_DUT];
  logic [4:0] lv   [N_DUT];
  logic [7:0] rnd  [N_DUT];
  logic [7:0] ms   [N_DUT];
  logic       act  [N_DUT];
  logic       go   [N_DUT];

  exp_t        sb[$];
  exp_t        e_mon;
  int          cyc = 0;
  int          ref_cyc = 0;
  int          sel = 0;
  bit          hit_mode = 1'b0;
  bit          force_mode = 1'b0;
  int          exp_misses = 0;
  logic [4:0]  last_pat = 5'b00000;
  logic        prev_ld = 1'b0;
  int          age = 0;
  logic [15:0] mace, mace_prev, m1, m1_prev;
  int          n_vec = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mole_spawner #(.TICKS_INIT(32'd8), .TICKS_STEP(32'd2), .TICKS_MIN(32'd4),
                 .ROUNDS(8'd3), .LFSR_SEED(16'hACE1)) u_a (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .board_state(board_state),
    .load(ld[0]), .loadval(lv[0]), .round(rnd[0]), .misses(ms[0]),
    .active(act[0]), .game_over(go[0]));

  mole_spawner #(.TICKS_INIT(32'd5), .TICKS_STEP(32'd4), .TICKS_MIN(32'd3),
                 .ROUNDS(8'd4), .LFSR_SEED(16'hACE1)) u_b (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .board_state(board_state),
    .load(ld[1]), .loadval(lv[1]), .round(rnd[1]), .misses(ms[1]),
    .active(act[1]), .game_over(go[1]));

  mole_spawner #(.TICKS_INIT(32'd3), .TICKS_STEP(32'd1), .TICKS_MIN(32'd2),
                 .ROUNDS(8'd60), .LFSR_SEED(16'hACE1)) u_c (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .board_state(board_state),
    .load(ld[2]), .loadval(lv[2]), .round(rnd[2]), .misses(ms[2]),
    .active(act[2]), .game_over(go[2]));

  mole_spawner #(.TICKS_INIT(32'd8), .TICKS_STEP(32'd2), .TICKS_MIN(32'd4),
                 .ROUNDS(8'd1), .LFSR_SEED(16'h0000)) u_d (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .board_state(board_state),
    .load(ld[3]), .loadval(lv[3]), .round(rnd[3]), .misses(ms[3]),
    .active(act[3]), .game_over(go[3]));

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [15:0] lfsr_nx(input logic [15:0] q);
    logic [15:0] n;
    n = q >> 1;
    if (q[0]) n = n ^ 16'hB400;
    return n;
  endfunction

  function automatic logic [4:0] nz5(input logic [15:0] q);
    return (q[4:0] == 5'd0) ? 5'd1 : q[4:0];
  endfunction

  function automatic int pop5(input logic [4:0] v);
    int c;
    c = 0;
    for (int i = 0; i < 5; i++) if (v[i]) c++;
    return c;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Reference LFSRs: seed ACE1 and seed 0001, reset alongside the DUTs.
  always @(posedge clk) begin
    mace_prev <= mace;
    m1_prev   <= m1;
    if (rst_n !== 1'b1) begin
      mace <= 16'hACE1;
      m1   <= 16'h0001;
    end else begin
      mace <= lfsr_nx(mace);
      m1   <= lfsr_nx(m1);
    end
  end

  // Board register model: loads on load, optionally forced to all moles,
  // optionally wiped by the player at the end of the first HOLD cycle.
  always @(posedge clk) begin
    if (rst_n !== 1'b1) begin
      board_state <= 5'b00000;
      age         <= 0;
    end else if (ld[sel] === 1'b1) begin
      board_state <= (force_mode && lv[sel] != 5'd0) ? 5'h1F : lv[sel];
      age         <= 0;
    end else begin
      if (hit_mode && age == 0) board_state <= 5'b00000;
      if (age < 1000) age <= age + 1;
    end
  end

  // Load monitor: pops the scoreboard on each load of the selected DUT.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (st[sel] === 1'b1 && sb.size() > 0 && sb[0].first) ref_cyc = cyc;
      if (ld[sel] === 1'b1) begin
        chk("no_back_to_back", {31'd0, prev_ld}, 0);
        if (sb.size() == 0) begin
          chk("unexpected_load", 1, 0);
        end else begin
          e_mon = sb.pop_front();
          chk("gap", cyc - ref_cyc, e_mon.gap);
          if (e_mon.first) exp_misses = 0;
          else if (!hit_mode) begin
            exp_misses = exp_misses + pop5(last_pat);
            if (exp_misses > 255) exp_misses = 255;
          end
          chk("misses", {24'd0, ms[sel]}, exp_misses);
          chk("active", {31'd0, act[sel]}, e_mon.clear ? 0 : 1);
          if (e_mon.clear) begin
            chk("clear_val", {27'd0, lv[sel]}, 0);
          end else begin
            chk("spawn_val", {27'd0, lv[sel]}, {27'd0, nz5(sel == 3 ? m1_prev : mace_prev)});
            last_pat = force_mode ? 5'h1F : lv[sel];
          end
          ref_cyc = cyc;
        end
      end
      prev_ld = ld[sel];
    end
  end

  task automatic run_game(input int s, input int init, input int step, input int mn,
                          input int rounds, input bit hit, input bit frc);
    int iv;
    int budget;
    sel        = s;
    hit_mode   = hit;
    force_mode = frc;
    sb.delete();
    sb.push_back('{1, 1'b0, 1'b1});
    iv = init;
    for (int r = 0; r < rounds; r++) begin
      sb.push_back('{(hit ? 2 : iv) + 1, (r == rounds - 1), 1'b0});
      iv = iv - step;
      if (iv < mn) iv = mn;
    end
    @(posedge clk); #1 st[s] = 1'b1;
    @(posedge clk); #1 st[s] = 1'b0;
    budget = 0;
    while (sb.size() != 0 && budget < 5000) begin
      @(posedge clk);
      budget++;
    end
    chk("game_timeout", sb.size(), 0);
    @(posedge clk); #1;
    chk("game_over", {31'd0, go[s]}, 1);
    chk("final_round", {24'd0, rnd[s]}, rounds - 1);
    chk("final_misses", {24'd0, ms[s]}, exp_misses);
    chk("done_active", {31'd0, act[s]}, 0);
    chk("done_load", {31'd0, ld[s]}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
    $fatal(1);
  end

  initial begin
    int nld;
    for (int i = 0; i < N_DUT; i++) st[i] = 1'b0;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    for (int i = 0; i < N_DUT; i++) begin
      chk("idle_load", {31'd0, ld[i]}, 0);
      chk("idle_active", {31'd0, act[i]}, 0);
      chk("idle_game_over", {31'd0, go[i]}, 0);
      chk("idle_round", {24'd0, rnd[i]}, 0);
      chk("idle_misses", {24'd0, ms[i]}, 0);
    end

    // Untouched board: full-length rounds 8/6/4, misses accumulate.
    run_game(0, 8, 2, 4, 3, 1'b0, 1'b0);
    // Restart from DONE, board wiped in 2nd HOLD cycle: early ends, no misses.
    run_game(0, 8, 2, 4, 3, 1'b1, 1'b0);
    // Interval floor without wrap: 5, 3, 3, 3.
    run_game(1, 5, 4, 3, 4, 1'b0, 1'b0);
    // All five moles expire every round: misses saturate at 255.
    run_game(2, 3, 1, 2, 60, 1'b0, 1'b1);
    chk("miss_saturate", {24'd0, ms[2]}, 255);
    // Zero seed behaves like seed 0001.
    run_game(3, 8, 2, 4, 1, 1'b0, 1'b0);

    // Mid-game abort with an ignored start pulse during HOLD.
    sel = 0; hit_mode = 1'b0; force_mode = 1'b0;
    sb.delete();
    sb.push_back('{1, 1'b0, 1'b1});
    sb.push_back('{9, 1'b0, 1'b0});
    @(posedge clk); #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1 st[0] = 1'b1;
    @(posedge clk); #1 st[0] = 1'b0;
    repeat (8) @(posedge clk);
    #1;
    chk("pre_abort_round", {24'd0, rnd[0]}, 1);
    chk("pre_abort_active", {31'd0, act[0]}, 1);
    rst_n = 1'b0;
    @(posedge clk); #1 rst_n = 1'b1;
    chk("abort_sb", sb.size(), 0);
    chk("abort_load", {31'd0, ld[0]}, 0);
    chk("abort_active", {31'd0, act[0]}, 0);
    chk("abort_game_over", {31'd0, go[0]}, 0);
    chk("abort_round", {24'd0, rnd[0]}, 0);
    chk("abort_misses", {24'd0, ms[0]}, 0);
    nld = 0;
    repeat (10) begin
      @(negedge clk);
      if (ld[0] === 1'b1) nld++;
    end
    chk("abort_no_clear_load", nld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
